// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-PC prediction unit.
//   - Opcode constants for the control instructions resolved in execute.
//   - Encodings for the 2-bit saturating branch counters.
//   - Small helpers: control-opcode test and saturating counter steps.
package pc_pkg;

    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_JAL = 5'b00011;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] OP_BLT = 5'b00110;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } satCounterT;

    function automatic logic isControlOp(input logic [4:0] op);
        return (op == OP_J) || (op == OP_BNE) || (op == OP_JAL) ||
               (op == OP_JR) || (op == OP_BLT);
    endfunction

    function automatic satCounterT counterUp(input satCounterT c);
        case (c)
            SNT:     return WNT;
            WNT:     return WT;
            default: return ST;
        endcase
    endfunction

    function automatic satCounterT counterDown(input satCounterT c);
        case (c)
            ST:      return WT;
            WT:      return WNT;
            default: return SNT;
        endcase
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   lookupPC              - fetch address to predict for
//   predTaken/predTarget  - combinational prediction for lookupPC
//   updateEn              - a resolved control instruction is written this edge
//   updatePC              - PC of the resolved instruction (gives index/tag)
//   updateTaken           - actual outcome of the resolved instruction
//   updateTarget          - actual target of the resolved instruction
// Lookup reads the stored state only, so a same-cycle write to the same index
// is seen by lookups from the following cycle onwards.
module pc_btb
    import pc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] lookupPC,
    output logic             predTaken,
    output logic [WIDTH-1:0] predTarget,
    input  logic             updateEn,
    input  logic [WIDTH-1:0] updatePC,
    input  logic             updateTaken,
    input  logic [WIDTH-1:0] updateTarget
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = WIDTH - IDX_W;

    logic             validArr   [BTB_ENTRIES];
    logic [TAG_W-1:0] tagArr     [BTB_ENTRIES];
    logic [WIDTH-1:0] targetArr  [BTB_ENTRIES];
    satCounterT       counterArr [BTB_ENTRIES];

    logic [IDX_W-1:0] lookIdx;
    logic [TAG_W-1:0] lookTag;
    logic             lookHit;
    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] updTag;
    logic             updHit;

    assign lookIdx = lookupPC[IDX_W-1:0];
    assign lookTag = lookupPC[WIDTH-1:IDX_W];
    assign lookHit = validArr[lookIdx] && (tagArr[lookIdx] == lookTag);

    // Only the upper counter bit decides the direction.
    assign predTaken  = lookHit && counterArr[lookIdx][1];
    assign predTarget = predTaken ? targetArr[lookIdx] : (lookupPC + WIDTH'(1));

    assign updIdx = updatePC[IDX_W-1:0];
    assign updTag = updatePC[WIDTH-1:IDX_W];
    assign updHit = validArr[updIdx] && (tagArr[updIdx] == updTag);

    // One register slice per entry; reset clears every entry at once, so a
    // write in flight when reset rises leaves nothing behind.
    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : gEntry
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    validArr[gi]   <= 1'b0;
                    tagArr[gi]     <= '0;
                    targetArr[gi]  <= '0;
                    counterArr[gi] <= WNT;
                end else if (updateEn && (updIdx == IDX_W'(gi))) begin
                    if (updateTaken) begin
                        targetArr[gi] <= updateTarget;
                        if (updHit) begin
                            counterArr[gi] <= counterUp(counterArr[gi]);
                        end else begin
                            // Allocation replaces whatever aliased here.
                            validArr[gi]   <= 1'b1;
                            tagArr[gi]     <= updTag;
                            counterArr[gi] <= WT;
                        end
                    end else if (updHit) begin
                        counterArr[gi] <= counterDown(counterArr[gi]);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-PC unit with BTB-based next-PC prediction.
// Ports:
//   clock, reset                      - rising-edge clock, async active-high reset
//   stall                             - hold the fetch PC (hazard)
//   fetchPC                           - current fetch address
//   fetchPredTaken/fetchPredTarget    - prediction for fetchPC, carried to execute
//   executeValid/PC/Opcode            - instruction in execute
//   executeT/A/Immediate, neq, lt     - operands used to resolve the outcome
//   executePredTaken/Target           - prediction that travelled with it
//   flush                             - kill fetch/decode on a mispredict
//   branchCount/mispredictCount       - statistics since reset
module pc_predict_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               BTB_ENTRIES = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    output logic [WIDTH-1:0] fetchPC,
    output logic             fetchPredTaken,
    output logic [WIDTH-1:0] fetchPredTarget,
    input  logic             executeValid,
    input  logic [WIDTH-1:0] executePC,
    input  logic [4:0]       executeOpcode,
    input  logic [WIDTH-1:0] executeT,
    input  logic [WIDTH-1:0] executeA,
    input  logic [WIDTH-1:0] executeImmediate,
    input  logic             neq,
    input  logic             lt,
    input  logic             executePredTaken,
    input  logic [WIDTH-1:0] executePredTarget,
    output logic             flush,
    output logic [WIDTH-1:0] branchCount,
    output logic [WIDTH-1:0] mispredictCount
);

    logic [WIDTH-1:0] pcReg;
    logic [WIDTH-1:0] pcNext;
    logic [WIDTH-1:0] branchCountReg;
    logic [WIDTH-1:0] mispredictCountReg;

    logic             isControl;
    logic             actTaken;
    logic [WIDTH-1:0] actTarget;
    logic [WIDTH-1:0] seqNext;
    logic [WIDTH-1:0] branchTarget;
    logic [WIDTH-1:0] correctNext;
    logic             mispredict;
    logic             btbUpdateEn;

    // Misprediction is judged purely on the carried target, so the carried
    // direction bit is not needed here.
    logic unusedPredTaken;
    assign unusedPredTaken = executePredTaken;

    assign seqNext      = executePC + WIDTH'(1);
    assign branchTarget = executePC + WIDTH'(1) + executeImmediate;

    always_comb begin
        isControl = 1'b0;
        actTaken  = 1'b0;
        actTarget = seqNext;
        case (executeOpcode)
            OP_J, OP_JAL: begin
                isControl = 1'b1;
                actTaken  = 1'b1;
                actTarget = executeT;
            end
            OP_JR: begin
                isControl = 1'b1;
                actTaken  = 1'b1;
                actTarget = executeA;
            end
            OP_BNE: begin
                isControl = 1'b1;
                actTaken  = neq;
                actTarget = branchTarget;
            end
            OP_BLT: begin
                isControl = 1'b1;
                actTaken  = lt;
                actTarget = branchTarget;
            end
            default: ;
        endcase
    end

    assign correctNext = actTaken ? actTarget : seqNext;

    // A stale prediction on a non-control instruction also mispredicts.
    assign mispredict  = executeValid && (executePredTarget != correctNext);
    assign flush       = mispredict && !reset;
    assign btbUpdateEn = executeValid && isCtrlGate(isControl);

    function automatic logic isCtrlGate(input logic c);
        return c;
    endfunction

    pc_btb #(
        .WIDTH       (WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) uBtb (
        .clock        (clock),
        .reset        (reset),
        .lookupPC     (pcReg),
        .predTaken    (fetchPredTaken),
        .predTarget   (fetchPredTarget),
        .updateEn     (btbUpdateEn),
        .updatePC     (executePC),
        .updateTaken  (actTaken),
        .updateTarget (actTarget)
    );

    // Redirect beats stall: a held PC would refetch down the wrong path.
    always_comb begin
        pcNext = fetchPredTarget;
        if (mispredict) begin
            pcNext = correctNext;
        end else if (stall) begin
            pcNext = pcReg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcReg              <= RESET_PC;
            branchCountReg     <= '0;
            mispredictCountReg <= '0;
        end else begin
            pcReg <= pcNext;
            if (btbUpdateEn) begin
                branchCountReg <= branchCountReg + WIDTH'(1);
            end
            if (mispredict) begin
                mispredictCountReg <= mispredictCountReg + WIDTH'(1);
            end
        end
    end

    assign fetchPC         = pcReg;
    assign branchCount     = branchCountReg;
    assign mispredictCount = mispredictCountReg;

endmodule
